link_sync_mon: RTL and testbench

Parametrised successor to the CSC fiber sync monitor. Checks NLINK optical trigger links every cycle: frame-marker K-characters must be valid and identical across all checked links, and no link may report a delayed trigger error. Adds per-link fault attribution, saturating per-link error counters, a programmable bad-run threshold and software-clearable sticky flags. Sits after the CFEB/GEM receive alignment logic; outputs feed status registers and the sync-error path.

---
 rtl/link_sync_mon.sv | 115 +++++++++++
 tb/tb_link_sync_mon.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/link_sync_mon.sv
// link_sync_mon: per-cycle sync monitor for NLINK trigger links with fault attribution
//   in : clock, global_reset_n (async, active low), ttc_resync, kchar[8*NLINK], link_en, link_good,
//        lt_trg_err, sync_done, rxd_int_delay[4], err_thresh[THRW], lostsync_clr
//   out: synced, lostsync (sticky), link_lostsync (sticky), link_err_cnt[CNTW*NLINK], mon_active
module link_sync_mon #(
  parameter int          NLINK   = 5,
  parameter logic [7:0]  KCHAR_A = 8'hBC,
  parameter logic [7:0]  KCHAR_B = 8'hFC,
  parameter int          CNTW    = 8,
  parameter int          THRW    = 4,
  parameter int          GOODW   = 2
) (
  input  logic                  clock,
  input  logic                  global_reset_n,
  input  logic                  ttc_resync,
  input  logic [8*NLINK-1:0]    kchar,
  input  logic [NLINK-1:0]      link_en,
  input  logic [NLINK-1:0]      link_good,
  input  logic [NLINK-1:0]      lt_trg_err,
  input  logic [NLINK-1:0]      sync_done,
  input  logic [3:0]            rxd_int_delay,
  input  logic [THRW-1:0]       err_thresh,
  input  logic                  lostsync_clr,
  output logic                  synced,
  output logic                  lostsync,
  output logic [NLINK-1:0]      link_lostsync,
  output logic [CNTW*NLINK-1:0] link_err_cnt,
  output logic                  mon_active
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_MONITOR} state_t;
  state_t state_q, state_d;
  logic [NLINK-1:0][15:0] err_sr_q, err_sr_d;
  logic [15:0] done_sr_q, done_sr_d;
  logic [NLINK-1:0][GOODW-1:0] good_cnt_q, good_cnt_d;
  logic [NLINK-1:0][CNTW-1:0] err_cnt_q, err_cnt_d;
  logic [NLINK-1:0] link_lost_q, link_lost_d;
  logic [THRW-1:0] run_q, run_d, thr;
  logic synced_q, synced_d, lostsync_q, lostsync_d, mon_active_q, mon_active_d;
  logic [NLINK-1:0] checked, bad, dly_err;
  logic [7:0] ref_k;
  logic gbad, cycle_bad, in_mon, done_dly;
  always_comb begin
    done_sr_d = {done_sr_q[14:0], &(sync_done | ~link_en)};
    done_dly = done_sr_q[rxd_int_delay];
    err_sr_d = err_sr_q;
    good_cnt_d = good_cnt_q;
    checked = '0;
    dly_err = '0;
    ref_k = KCHAR_A;
    // descending scan so the lowest-index checked link ends up as reference
    for (int i = NLINK - 1; i >= 0; i--) begin
      err_sr_d[i] = {err_sr_q[i][14:0], lt_trg_err[i]};
      dly_err[i] = err_sr_q[i][rxd_int_delay];
      good_cnt_d[i] = !(link_en[i] && link_good[i]) ? '0 :
                      (&good_cnt_q[i]) ? good_cnt_q[i] : good_cnt_q[i] + GOODW'(1);
      checked[i] = link_en[i] & link_good[i] & (&good_cnt_q[i]);
      if (checked[i]) ref_k = kchar[8*i +: 8];
    end
    bad = '0;
    gbad = 1'b0;
    for (int i = 0; i < NLINK; i++) begin
      bad[i] = checked[i] & (((kchar[8*i +: 8] != KCHAR_A) && (kchar[8*i +: 8] != KCHAR_B)) ||
                             (kchar[8*i +: 8] != ref_k) || dly_err[i]);
      // trigger errors on enabled-but-unsettled links still count, just unattributed
      gbad = gbad | (link_en[i] & ~checked[i] & dly_err[i]);
    end
    cycle_bad = (|checked) & ((|bad) | gbad);
    in_mon = (state_q == S_MONITOR);
    thr = (err_thresh == '0) ? THRW'(1) : err_thresh;
    run_d = (in_mon && cycle_bad) ? ((&run_q) ? run_q : run_q + THRW'(1)) : '0;
    synced_d = !(in_mon && (run_d >= thr));
    lostsync_d = (lostsync_q & ~lostsync_clr) | ~synced_d;
    link_lost_d = '0;
    err_cnt_d = err_cnt_q;
    for (int i = 0; i < NLINK; i++) begin
      link_lost_d[i] = (link_lost_q[i] & ~lostsync_clr) | (in_mon & bad[i]);
      err_cnt_d[i] = (in_mon && bad[i]) ? (lostsync_clr ? CNTW'(1) :
                                           (&err_cnt_q[i]) ? err_cnt_q[i] : err_cnt_q[i] + CNTW'(1)) :
                     lostsync_clr ? '0 : err_cnt_q[i];
    end
    state_d = ttc_resync ? S_IDLE : (state_q == S_IDLE) ? S_WAIT_DONE :
              done_dly ? S_MONITOR : S_WAIT_DONE;
    mon_active_d = (state_d == S_MONITOR);
  end
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q <= S_IDLE;
      err_sr_q <= '0;
      done_sr_q <= '0;
      good_cnt_q <= '0;
      err_cnt_q <= '0;
      link_lost_q <= '0;
      run_q <= '0;
      synced_q <= 1'b1;
      lostsync_q <= 1'b0;
      mon_active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_sr_q <= err_sr_d;
      done_sr_q <= done_sr_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q <= err_cnt_d;
      link_lost_q <= link_lost_d;
      run_q <= run_d;
      synced_q <= synced_d;
      lostsync_q <= lostsync_d;
      mon_active_q <= mon_active_d;
    end
  end
  assign synced = synced_q;
  assign lostsync = lostsync_q;
  assign link_lostsync = link_lost_q;
  assign link_err_cnt = err_cnt_q;
  assign mon_active = mon_active_q;
endmodule

// File: tb/tb_link_sync_mon.sv
// tb_link_sync_mon: directed and random checks of link_sync_mon against a behavioural model
module tb_link_sync_mon;
  localparam int NLINK = 5;
  localparam int CNTW = 8;
  localparam int THRW = 4;
  localparam int GOODW = 2;
  localparam logic [7:0] KA = 8'hBC;
  localparam logic [7:0] KB = 8'hFC;
  localparam int GOODMAX = (1 << GOODW) - 1;
  localparam int CNTMAX = (1 << CNTW) - 1;
  localparam int RUNMAX = (1 << THRW) - 1;
  logic clock = 1'b0;
  logic global_reset_n = 1'b0;
  logic ttc_resync = 1'b0;
  logic [8*NLINK-1:0] kchar = {NLINK{KA}};
  logic [NLINK-1:0] link_en = '1;
  logic [NLINK-1:0] link_good = '1;
  logic [NLINK-1:0] lt_trg_err = '0;
  logic [NLINK-1:0] sync_done = '1;
  logic [3:0] rxd_int_delay = 4'd0;
  logic [THRW-1:0] err_thresh = THRW'(1);
  logic lostsync_clr = 1'b0;
  logic synced, lostsync, mon_active;
  logic [NLINK-1:0] link_lostsync;
  logic [CNTW*NLINK-1:0] link_err_cnt;
  int tests = 0;
  int fails = 0;
  int m_phase, m_run;
  int m_cnt [NLINK];
  int good_run [NLINK];
  bit m_synced, m_lost;
  logic [NLINK-1:0] m_llost;
  logic [NLINK-1:0] eh [$];
  bit dh [$];
  link_sync_mon #(.NLINK(NLINK), .KCHAR_A(KA), .KCHAR_B(KB), .CNTW(CNTW), .THRW(THRW), .GOODW(GOODW)) dut (
    .clock(clock), .global_reset_n(global_reset_n), .ttc_resync(ttc_resync), .kchar(kchar),
    .link_en(link_en), .link_good(link_good), .lt_trg_err(lt_trg_err), .sync_done(sync_done),
    .rxd_int_delay(rxd_int_delay), .err_thresh(err_thresh), .lostsync_clr(lostsync_clr),
    .synced(synced), .lostsync(lostsync), .link_lostsync(link_lostsync),
    .link_err_cnt(link_err_cnt), .mon_active(mon_active)
  );
  always #5 clock = ~clock;
  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic check(input string tag);
    logic [CNTW*NLINK-1:0] ec;
    for (int i = 0; i < NLINK; i++) ec[CNTW*i +: CNTW] = CNTW'(m_cnt[i]);
    expect_eq({tag, ".synced"}, 64'(synced), 64'(m_synced));
    expect_eq({tag, ".lostsync"}, 64'(lostsync), 64'(m_lost));
    expect_eq({tag, ".link_lostsync"}, 64'(link_lostsync), 64'(m_llost));
    expect_eq({tag, ".link_err_cnt"}, 64'(link_err_cnt), 64'(ec));
    expect_eq({tag, ".mon_active"}, 64'(mon_active), 64'(m_phase == 2));
  endtask
  task automatic model_reset();
    m_phase = 0; m_run = 0; m_synced = 1; m_lost = 0; m_llost = '0;
    eh.delete(); dh.delete();
    for (int i = 0; i < 16; i++) begin eh.push_back('0); dh.push_back(1'b0); end
    for (int i = 0; i < NLINK; i++) begin m_cnt[i] = 0; good_run[i] = 0; end
  endtask
  // advance the reference one clock using the current inputs, then compare after the edge
  task automatic tick(input string tag);
    logic [NLINK-1:0] chk, bd, de;
    logic [7:0] rk, k;
    bit gb, cb, inm, dd;
    int thr;
    rk = KA; gb = 0; chk = '0; bd = '0;
    de = eh[rxd_int_delay];
    for (int i = 0; i < NLINK; i++) chk[i] = link_en[i] && link_good[i] && good_run[i] >= GOODMAX;
    for (int i = 0; i < NLINK; i++) if (chk[i]) begin rk = kchar[8*i +: 8]; break; end
    for (int i = 0; i < NLINK; i++) begin
      k = kchar[8*i +: 8];
      bd[i] = chk[i] && (!(k == KA || k == KB) || k != rk || de[i]);
      if (link_en[i] && !chk[i] && de[i]) gb = 1;
    end
    cb = (chk != 0) && ((bd != 0) || gb);
    inm = (m_phase == 2);
    dd = dh[rxd_int_delay];
    thr = (err_thresh == 0) ? 1 : int'(err_thresh);
    m_run = (inm && cb) ? ((m_run < RUNMAX) ? m_run + 1 : RUNMAX) : 0;
    m_synced = !(inm && m_run >= thr);
    m_lost = (m_lost && !lostsync_clr) || !m_synced;
    for (int i = 0; i < NLINK; i++) begin
      if (lostsync_clr) begin m_llost[i] = 0; m_cnt[i] = 0; end
      if (inm && bd[i]) begin m_llost[i] = 1; m_cnt[i] = (m_cnt[i] < CNTMAX) ? m_cnt[i] + 1 : CNTMAX; end
      good_run[i] = (link_en[i] && link_good[i]) ? ((good_run[i] < 1000) ? good_run[i] + 1 : 1000) : 0;
    end
    m_phase = ttc_resync ? 0 : (m_phase == 0) ? 1 : dd ? 2 : 1;
    eh.push_front(lt_trg_err); void'(eh.pop_back());
    dh.push_front(&(sync_done | ~link_en)); void'(dh.pop_back());
    @(posedge clock); #1;
    check(tag);
  endtask
  initial begin
    int j, r;
    #23;
    expect_eq("rst.synced", 64'(synced), 64'd1);
    expect_eq("rst.lostsync", 64'(lostsync), 64'd0);
    expect_eq("rst.link_lostsync", 64'(link_lostsync), 64'd0);
    expect_eq("rst.link_err_cnt", 64'(link_err_cnt), 64'd0);
    expect_eq("rst.mon_active", 64'(mon_active), 64'd0);
    @(posedge clock); #1;
    global_reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) tick("startup");
    expect_eq("startup.mon_active", 64'(mon_active), 64'd1);
    expect_eq("startup.synced", 64'(synced), 64'd1);
    kchar[8*2 +: 8] = 8'h3C;
    tick("badk");
    kchar[8*2 +: 8] = KA;
    expect_eq("badk.synced", 64'(synced), 64'd0);
    expect_eq("badk.link_lostsync", 64'(link_lostsync), 64'b00100);
    expect_eq("badk.cnt2", 64'(link_err_cnt[8*2 +: 8]), 64'd1);
    tick("badk_recover");
    expect_eq("badk_recover.synced", 64'(synced), 64'd1);
    expect_eq("badk_recover.lostsync", 64'(lostsync), 64'd1);
    lostsync_clr = 1'b1;
    tick("clr1");
    lostsync_clr = 1'b0;
    err_thresh = THRW'(3);
    kchar[8*3 +: 8] = KB;
    for (int c = 0; c < 2; c++) tick("thr_run2");
    expect_eq("thr_run2.synced", 64'(synced), 64'd1);
    kchar[8*3 +: 8] = KA;
    tick("thr_gap");
    kchar[8*3 +: 8] = KB;
    for (int c = 0; c < 3; c++) tick("thr_run3");
    kchar[8*3 +: 8] = KA;
    expect_eq("thr_run3.synced", 64'(synced), 64'd0);
    expect_eq("thr_run3.cnt3", 64'(link_err_cnt[8*3 +: 8]), 64'd5);
    tick("thr_after");
    err_thresh = THRW'(1);
    link_en[4] = 1'b0;
    kchar[8*4 +: 8] = 8'h00;
    for (int c = 0; c < 3; c++) tick("dis4");
    link_good[1] = 1'b0;
    kchar[8*1 +: 8] = 8'h55;
    tick("good1_low");
    link_good[1] = 1'b1;
    for (int c = 0; c < 3; c++) tick("good1_settle");
    expect_eq("good1_settle.cnt1", 64'(link_err_cnt[8*1 +: 8]), 64'd0);
    expect_eq("good1_settle.synced", 64'(synced), 64'd1);
    kchar[8*1 +: 8] = KA;
    link_en[4] = 1'b1;
    kchar[8*4 +: 8] = KA;
    for (int c = 0; c < 5; c++) tick("reenable4");
    lostsync_clr = 1'b1;
    rxd_int_delay = 4'd7;
    tick("clr2");
    lostsync_clr = 1'b0;
    for (int c = 0; c < 3; c++) tick("dly_settle");
    lt_trg_err[3] = 1'b1;
    tick("dly_pulse");
    lt_trg_err[3] = 1'b0;
    for (int c = 0; c < 7; c++) tick("dly_wait");
    expect_eq("dly_n8.synced", 64'(synced), 64'd1);
    tick("dly_hit");
    expect_eq("dly_n9.synced", 64'(synced), 64'd0);
    expect_eq("dly_n9.cnt3", 64'(link_err_cnt[8*3 +: 8]), 64'd1);
    rxd_int_delay = 4'd0;
    kchar[8*1 +: 8] = 8'h00;
    for (int c = 0; c < 300; c++) tick("sat");
    expect_eq("sat.cnt1", 64'(link_err_cnt[8*1 +: 8]), 64'd255);
    kchar[8*1 +: 8] = KA;
    ttc_resync = 1'b1;
    tick("resync");
    ttc_resync = 1'b0;
    expect_eq("resync.synced", 64'(synced), 64'd1);
    expect_eq("resync.mon_active", 64'(mon_active), 64'd0);
    expect_eq("resync.lostsync", 64'(lostsync), 64'd1);
    expect_eq("resync.cnt1", 64'(link_err_cnt[8*1 +: 8]), 64'd255);
    lostsync_clr = 1'b1;
    tick("clr3");
    lostsync_clr = 1'b0;
    expect_eq("clr3.lostsync", 64'(lostsync), 64'd0);
    expect_eq("clr3.link_lostsync", 64'(link_lostsync), 64'd0);
    expect_eq("clr3.link_err_cnt", 64'(link_err_cnt), 64'd0);
    for (int c = 0; c < 400; c++) begin
      r = int'($urandom_range(0, 99));
      j = int'($urandom_range(0, NLINK - 1));
      kchar = {NLINK{KA}};
      if (r < 10) kchar = {NLINK{KB}};
      else if (r < 25) kchar[8*j +: 8] = 8'($urandom);
      link_en = '1;
      link_good = '1;
      if ($urandom_range(0, 24) == 0) link_en[int'($urandom_range(0, NLINK - 1))] = 1'b0;
      if ($urandom_range(0, 24) == 0) link_good[int'($urandom_range(0, NLINK - 1))] = 1'b0;
      lt_trg_err = '0;
      if ($urandom_range(0, 14) == 0) lt_trg_err[int'($urandom_range(0, NLINK - 1))] = 1'b1;
      sync_done = ($urandom_range(0, 29) == 0) ? '0 : '1;
      if ($urandom_range(0, 49) == 0) rxd_int_delay = 4'($urandom);
      if ($urandom_range(0, 29) == 0) err_thresh = THRW'($urandom_range(0, 4));
      lostsync_clr = ($urandom_range(0, 19) == 0);
      ttc_resync = ($urandom_range(0, 59) == 0);
      tick("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
